ber_align: RTL and testbench
============================

Name: ber_align

Overview:
Parametrised BER checker for the PRBS loopback chain. It finds the received-to-reference bit latency automatically by sweeping a reference delay line, locks, then accumulates bit and error counts. It detects loss of lock (e.g. RX phase switch) and re-searches. It replaces the fixed-latency BER block and sits between PRBS/RX outputs and the LED/status logic.

Parameters:
MAX_DLY  511  largest searchable latency, in bit strobes; delay line length MAX_DLY+1
DLY_W  9  width of delay index; must satisfy 2^DLY_W > MAX_DLY
SEARCH_LEN  512  bits compared per candidate trial; also the MEASURE loss-of-lock window length
LOCK_ERR  0  max trial errors for a candidate to be accepted
LOL_THR  128  window error count above which lock is declared lost
CNT_W  32  width of bit/error accumulators

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
enable  in  1  one-cycle bit strobe; sx/dx valid only when high
sx  in  1  reference bit from PRBS
dx  in  1  received bit from RX
i_restart  in  1  synchronous pulse: clear counts, restart search
o_locked  out  1  high in MEASURE state
o_delay  out  DLY_W  locked latency; candidate under test while searching
o_err_cnt  out  CNT_W  errors since lock/restart
o_bit_cnt  out  CNT_W  bits compared since lock/restart
error_flag  out  1  !locked OR err_cnt != 0

Behaviour:
- Reset values: o_locked 0, o_delay 0, o_err_cnt 0, o_bit_cnt 0, error_flag 1, delay line all 0, state WARMUP.
- All state and outputs change only on clk edges where enable=1 or i_restart=1. Outputs are registered, so results are visible the cycle after the strobe.
- Delay line: on every enable, sx shifts in. tap[d] is sx from d strobes earlier (tap[0] is the current sx). Mismatch m = dx XOR tap[cand].
- WARMUP: count MAX_DLY enables with no comparisons, then go to SEARCH with cand=0. This stage only runs after reset, not after i_restart.
- SEARCH:
  - Each enable increments trial_bits and adds m to trial_err.
  - On the enable where trial_bits reaches SEARCH_LEN, evaluate total errors including that strobe's m:
    - If total <= LOCK_ERR: go to MEASURE, set o_delay=cand, clear err/bit counters, set o_locked=1.
    - Otherwise: cand = (cand==MAX_DLY) ? 0 : cand+1, and clear trial counters.
  - Search never times out; it cycles candidates indefinitely.
- MEASURE:
  - Each enable increments o_bit_cnt and adds m to o_err_cnt.
  - Both freeze once o_bit_cnt reaches all-ones; o_err_cnt also saturates independently.
  - A window counter of SEARCH_LEN enables tracks win_err, which is cleared at each window wrap.
  - On the enable where win_err exceeds LOL_THR: go to SEARCH with cand = o_delay+1 (wrapping to 0 past MAX_DLY), o_locked=0. o_err_cnt and o_bit_cnt hold their values (frozen).
- i_restart:
  - Overrides enable-driven state updates in the same cycle: go to SEARCH, cand=0, clear all counters, o_locked=0.
  - The delay line still shifts if enable is also high in that cycle.
  - During WARMUP, i_restart is ignored.
- error_flag is registered from the next-state values: 1 whenever not locked, otherwise (o_err_cnt != 0).
- Async reset at any point, including mid-MEASURE, returns everything to reset values immediately. WARMUP repeats afterwards.
- With enable low, every register holds.

Test Plan:
1. Defaults, PRBS9, dx = sx delayed 5 strobes -> 511 warmup strobes, candidates 0-4 fail. o_locked=1 and o_delay=5 one cycle after strobe 511+6*512=3583; error_flag 0; o_err_cnt=0.
2. Locked at delay 5, flip dx once every 100 strobes for 1000 strobes -> o_bit_cnt=1000, o_err_cnt=10, o_locked stays 1, error_flag=1.
3. Locked at 5, switch channel latency to 9 -> random mismatches push win_err past 128 within one window. o_locked drops, search resumes at 6, relocks with o_delay=9. Counters frozen during search, cleared on relock.
4. i_restart asserted together with enable while locked -> next cycle o_locked=0, counters 0, o_delay=0, error_flag=1. Relock with no warmup.
5. CNT_W=8, locked, error-free for 300 strobes -> o_bit_cnt holds 255, o_err_cnt 0.
6. Assert rst low mid-MEASURE between clock edges -> all outputs go to reset values without waiting for a clk edge. After release, lock occurs at the same strobe count as test 1.

Source files
------------

// File: rtl/ber_align.sv
// BER checker that sweeps a reference delay line to find the RX latency,
// locks onto it, then accumulates bit/error counts and re-searches on loss of lock.
module ber_align #(
  parameter int unsigned MAX_DLY    = 511,
  parameter int unsigned DLY_W      = 9,
  parameter int unsigned SEARCH_LEN = 512,
  parameter int unsigned LOCK_ERR   = 0,
  parameter int unsigned LOL_THR    = 128,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sx,
  input  logic             dx,
  input  logic             i_restart,
  output logic             o_locked,
  output logic [DLY_W-1:0] o_delay,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             error_flag
);

  localparam int unsigned TW = $clog2(SEARCH_LEN + 1);
  localparam logic [TW-1:0]    SLEN_T     = TW'(SEARCH_LEN);
  localparam logic [TW-1:0]    LOCK_ERR_T = TW'(LOCK_ERR);
  localparam logic [TW-1:0]    LOL_THR_T  = TW'(LOL_THR);
  localparam logic [DLY_W-1:0] MAX_DLY_T  = DLY_W'(MAX_DLY);
  localparam logic [DLY_W-1:0] WARM_LAST  = DLY_W'(MAX_DLY - 1);

  typedef enum logic [1:0] {WARMUP, SEARCH, MEASURE} state_t;

  state_t             state_q, state_d;
  logic [MAX_DLY-1:0] line_q, line_d;
  logic [DLY_W-1:0]   warm_q, warm_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic [TW-1:0]      trial_bits_q, trial_bits_d;
  logic [TW-1:0]      trial_err_q, trial_err_d;
  logic               locked_q, locked_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               flag_q, flag_d;

  logic [MAX_DLY:0]   full_line;
  logic               m;
  logic [TW-1:0]      bits_inc, err_inc;
  logic [DLY_W-1:0]   next_cand;

  always_comb begin
    full_line = {line_q, sx};
    m         = dx ^ full_line[delay_q];
    bits_inc  = trial_bits_q + 1'b1;
    err_inc   = trial_err_q + TW'(m);
    next_cand = (delay_q == MAX_DLY_T) ? '0 : delay_q + 1'b1;

    state_d      = state_q;
    line_d       = line_q;
    warm_d       = warm_q;
    delay_d      = delay_q;
    trial_bits_d = trial_bits_q;
    trial_err_d  = trial_err_q;
    locked_d     = locked_q;
    err_cnt_d    = err_cnt_q;
    bit_cnt_d    = bit_cnt_q;

    if (enable) line_d = {line_q[MAX_DLY-2:0], sx};

    // Restart wins over the strobe, but the delay line above still shifts.
    if (i_restart && state_q != WARMUP) begin
      state_d      = SEARCH;
      delay_d      = '0;
      trial_bits_d = '0;
      trial_err_d  = '0;
      locked_d     = 1'b0;
      err_cnt_d    = '0;
      bit_cnt_d    = '0;
    end else if (enable) begin
      case (state_q)
        WARMUP: begin
          warm_d = warm_q + 1'b1;
          if (warm_q == WARM_LAST) begin
            state_d      = SEARCH;
            warm_d       = '0;
            delay_d      = '0;
            trial_bits_d = '0;
            trial_err_d  = '0;
          end
        end
        SEARCH: begin
          trial_bits_d = bits_inc;
          trial_err_d  = err_inc;
          if (bits_inc == SLEN_T) begin
            trial_bits_d = '0;
            trial_err_d  = '0;
            if (err_inc <= LOCK_ERR_T) begin
              state_d   = MEASURE;
              locked_d  = 1'b1;
              err_cnt_d = '0;
              bit_cnt_d = '0;
            end else begin
              delay_d = next_cand;
            end
          end
        end
        MEASURE: begin
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (m && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
          // Trial counters double as the loss-of-lock window here.
          trial_bits_d = bits_inc;
          trial_err_d  = err_inc;
          if (err_inc > LOL_THR_T) begin
            state_d      = SEARCH;
            delay_d      = next_cand;
            locked_d     = 1'b0;
            trial_bits_d = '0;
            trial_err_d  = '0;
          end else if (bits_inc == SLEN_T) begin
            trial_bits_d = '0;
            trial_err_d  = '0;
          end
        end
        default: state_d = WARMUP;
      endcase
    end

    flag_d = !locked_d || (err_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WARMUP;
      line_q       <= '0;
      warm_q       <= '0;
      delay_q      <= '0;
      trial_bits_q <= '0;
      trial_err_q  <= '0;
      locked_q     <= 1'b0;
      err_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      flag_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      warm_q       <= warm_d;
      delay_q      <= delay_d;
      trial_bits_q <= trial_bits_d;
      trial_err_q  <= trial_err_d;
      locked_q     <= locked_d;
      err_cnt_q    <= err_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      flag_q       <= flag_d;
    end
  end

  assign o_locked   = locked_q;
  assign o_delay    = delay_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_bit_cnt  = bit_cnt_q;
  assign error_flag = flag_q;

endmodule

// File: tb/tb_ber_align.sv
// Scoreboard bench for ber_align: PRBS9 reference, configurable channel latency,
// expectations queued by the stimulus and checked by an independent monitor.
module tb_ber_align;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sx = 1'b0;
  logic        dx = 1'b0;
  logic        dx8 = 1'b0;
  logic        i_restart = 1'b0;
  logic        o_locked, error_flag, l8, f8;
  logic [8:0]  o_delay, d8;
  logic [31:0] o_err_cnt, o_bit_cnt;
  logic [7:0]  e8, b8;

  always #5 clk = ~clk;

  ber_align dut (
    .clk(clk), .rst(rst), .enable(enable), .sx(sx), .dx(dx), .i_restart(i_restart),
    .o_locked(o_locked), .o_delay(o_delay), .o_err_cnt(o_err_cnt),
    .o_bit_cnt(o_bit_cnt), .error_flag(error_flag)
  );

  // Narrow-counter instance sees a clean delay-5 channel and never restarts.
  ber_align #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .sx(sx), .dx(dx8), .i_restart(1'b0),
    .o_locked(l8), .o_delay(d8), .o_err_cnt(e8), .o_bit_cnt(b8), .error_flag(f8)
  );

  typedef struct {
    string       name;
    int          tag;
    int          unit;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [8:0]  lfsr = 9'h1FF;
  logic [31:0] sh = '0;
  int          lat = 5;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int u, input int k);
    if (u == 0) begin
      case (k)
        0: return 32'(o_locked);
        1: return 32'(o_delay);
        2: return o_err_cnt;
        3: return o_bit_cnt;
        default: return 32'(error_flag);
      endcase
    end
    case (k)
      0: return 32'(l8);
      1: return 32'(d8);
      2: return 32'(e8);
      3: return 32'(b8);
      default: return 32'(f8);
    endcase
  endfunction

  function automatic void want(input string nm, input int tg, input int u, input int k,
                               input logic [31:0] v);
    exp_t e;
    e.name = nm; e.tag = tg; e.unit = u; e.kind = k; e.val = v;
    sb.push_back(e);
  endfunction

  function automatic void want_all(input string nm, input int tg, input logic lk,
                                   input int dl, input int er, input int bt, input logic fl);
    want({nm, ".locked"}, tg, 0, 0, 32'(lk));
    want({nm, ".delay"},  tg, 0, 1, 32'(dl));
    want({nm, ".err"},    tg, 0, 2, 32'(er));
    want({nm, ".bits"},   tg, 0, 3, 32'(bt));
    want({nm, ".flag"},   tg, 0, 4, 32'(fl));
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      a = actual(e.unit, e.kind);
      total++;
      if (e.tag != cyc || a !== e.val) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d, due %0d)",
                 e.name, a, e.val, cyc, e.tag);
      end
    end
  end

  task automatic strobe(input bit flip, input bit rs);
    logic [32:0] ln;
    @(negedge clk);
    ln        = {sh, lfsr[8]};
    sx        = lfsr[8];
    dx        = ln[lat] ^ flip;
    dx8       = ln[5];
    enable    = 1'b1;
    i_restart = rs;
    sh        = ln[31:0];
    lfsr      = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable    = 1'b0;
      i_restart = 1'b0;
    end
  endtask

  // From reset: 511 warmup strobes, candidates 0..4 fail, candidate 5 locks at 3583.
  task automatic lock_from_reset(input string nm);
    int t;
    for (int i = 1; i <= 3583; i++) begin
      strobe(1'b0, 1'b0);
      t = cyc + 1;
      if (i == 511)  want_all({nm, "_warm_end"}, t, 1'b0, 0, 0, 0, 1'b1);
      if (i == 1022) want({nm, "_cand0_last"}, t, 0, 1, 32'd0);
      if (i == 1023) begin
        want({nm, "_cand1"}, t, 0, 1, 32'd1);
        idle(3);
        want({nm, "_hold.delay"}, cyc + 1, 0, 1, 32'd1);
        want({nm, "_hold.locked"}, cyc + 1, 0, 0, 32'd0);
      end
      if (i == 3582) begin
        want({nm, "_prelock.locked"}, t, 0, 0, 32'd0);
        want({nm, "_prelock.delay"}, t, 0, 1, 32'd5);
      end
      if (i == 3583) begin
        want_all({nm, "_lock"}, t, 1'b1, 5, 0, 0, 1'b0);
        want({nm, "_lock8.locked"}, t, 1, 0, 32'd1);
        want({nm, "_lock8.bits"}, t, 1, 3, 32'd0);
      end
    end
  endtask

  initial begin
    int  t;
    int  s0;
    bit  lost;

    @(posedge clk);
    #2;
    want_all("reset", cyc, 1'b0, 0, 0, 0, 1'b1);
    idle(2);
    rst = 1'b1;

    lock_from_reset("t1");

    for (int i = 0; i < 1000; i++) begin
      strobe((i % 100) == 99, 1'b0);
      t = cyc + 1;
      if (i == 98)  want_all("t2_clean", t, 1'b1, 5, 0, 99, 1'b0);
      if (i == 99)  want_all("t2_first_err", t, 1'b1, 5, 1, 100, 1'b1);
      if (i == 254) want("t5_reach.bits", t, 1, 3, 32'd255);
      if (i == 255) begin
        want("t5_sat.bits", t, 1, 3, 32'd255);
        want("t5_sat.err", t, 1, 2, 32'd0);
        want("t2_wide.bits", t, 0, 3, 32'd256);
      end
      if (i == 999) begin
        want_all("t2_end", t, 1'b1, 5, 10, 1000, 1'b1);
        want("t5_end.bits", t, 1, 3, 32'd255);
        want("t5_end.err", t, 1, 2, 32'd0);
        want("t5_end.locked", t, 1, 0, 32'd1);
        want("t5_end.flag", t, 1, 4, 32'd0);
      end
    end

    lat  = 9;
    lost = 1'b0;
    s0   = 0;
    while (!lost && s0 < 1024) begin
      strobe(1'b0, 1'b0);
      s0++;
      @(posedge clk);
      #1;
      if (!o_locked) lost = 1'b1;
    end
    if (!lost) begin
      total++;
      bad++;
      $display("FAIL t3_lol: got locked=1 after %0d strobes, expected lock loss", s0);
    end
    for (int j = 1; j <= 2048; j++) begin
      strobe(1'b0, 1'b0);
      t = cyc + 1;
      if (j == 1) begin
        want("t3_resume.delay", t, 0, 1, 32'd6);
        want("t3_resume.locked", t, 0, 0, 32'd0);
        want("t3_resume.flag", t, 0, 4, 32'd1);
      end
      if (j == 2047) begin
        want("t3_prelock.locked", t, 0, 0, 32'd0);
        want("t3_prelock.delay", t, 0, 1, 32'd9);
      end
      if (j == 2048) want_all("t3_relock", t, 1'b1, 9, 0, 0, 1'b0);
    end

    for (int j = 1; j <= 10; j++) begin
      strobe(1'b0, 1'b0);
      if (j == 10) want_all("t4_pre", cyc + 1, 1'b1, 9, 0, 10, 1'b0);
    end
    strobe(1'b0, 1'b1);
    want_all("t4_restart", cyc + 1, 1'b0, 0, 0, 0, 1'b1);
    for (int j = 1; j <= 5120; j++) begin
      strobe(1'b0, 1'b0);
      t = cyc + 1;
      if (j == 511)  want("t4_cand0_last", t, 0, 1, 32'd0);
      if (j == 512)  want("t4_cand1", t, 0, 1, 32'd1);
      if (j == 5119) begin
        want("t4_prelock.locked", t, 0, 0, 32'd0);
        want("t4_prelock.delay", t, 0, 1, 32'd9);
      end
      if (j == 5120) want_all("t4_relock", t, 1'b1, 9, 0, 0, 1'b0);
    end

    for (int j = 1; j <= 20; j++) begin
      strobe(1'b0, 1'b0);
      if (j == 20) want_all("t6_pre", cyc + 1, 1'b1, 9, 0, 20, 1'b0);
    end
    idle(1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    want_all("t6_async", cyc, 1'b0, 0, 0, 0, 1'b1);
    want("t6_async8.locked", cyc, 1, 0, 32'd0);
    want("t6_async8.bits", cyc, 1, 3, 32'd0);
    idle(2);
    rst  = 1'b1;
    lfsr = 9'h1FF;
    sh   = '0;
    lat  = 5;
    lock_from_reset("t6");

    idle(3);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
